// File: rtl/riscboy_ppu_ahbl_read_bridge.sv
// PPU read-only port to AHB-Lite bridge: halfword reads, in-order responses, one rdata_vld per request.
// Optional RISCBOY_PPU_BRIDGE_ERR_CAPTURE_EN adds err_addr, holding the address of the first failing read.
module riscboy_ppu_ahbl_read_bridge #(
    parameter int                   W_ADDR    = 18,
    parameter int                   W_HADDR   = 32,
    parameter logic [W_HADDR-1:0]   BASE_ADDR = 32'h2000_0000
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [W_ADDR-1:0]   mem_addr,
    input  logic                mem_addr_vld,
    output logic                mem_addr_rdy,
    output logic [15:0]         mem_rdata,
    output logic                mem_rdata_vld,

    output logic [W_HADDR-1:0]  ahbl_haddr,
    output logic [1:0]          ahbl_htrans,
    output logic                ahbl_hwrite,
    output logic [2:0]          ahbl_hsize,
    output logic [2:0]          ahbl_hburst,
    output logic [3:0]          ahbl_hprot,
    output logic                ahbl_hmastlock,
    input  logic                ahbl_hready,
    input  logic                ahbl_hresp,
    input  logic [31:0]         ahbl_hrdata,

    output logic                err_sticky,
`ifdef RISCBOY_PPU_BRIDGE_ERR_CAPTURE_EN
    output logic [W_HADDR-1:0]  err_addr,
`endif
    input  logic                err_clr
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic              aph_vld;
    logic [W_ADDR-1:0] aph_addr;
    logic              dph_vld;
    logic              dph_lane;
    logic              dph_done;
    logic              dph_err;

    // Halfword accesses only; the byte-select bit is dropped.
    logic unused_addr_lsb;
    assign unused_addr_lsb = mem_addr[0];

    assign mem_addr_rdy = !aph_vld || ahbl_hready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aph_vld  <= 1'b0;
            aph_addr <= '0;
        end else if (mem_addr_rdy) begin
            aph_vld  <= mem_addr_vld;
            aph_addr <= {mem_addr[W_ADDR-1:1], 1'b0};
        end
    end

    assign ahbl_haddr     = BASE_ADDR | {{(W_HADDR-W_ADDR){1'b0}}, aph_addr};
    assign ahbl_htrans    = aph_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahbl_hwrite    = 1'b0;
    assign ahbl_hsize     = 3'b001;
    assign ahbl_hburst    = 3'b000;
    assign ahbl_hprot     = 4'b0011;
    assign ahbl_hmastlock = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dph_vld  <= 1'b0;
            dph_lane <= 1'b0;
        end else if (ahbl_hready) begin
            dph_vld  <= aph_vld;
            dph_lane <= aph_addr[1];
        end
    end

    assign dph_done = dph_vld && ahbl_hready;
    assign dph_err  = dph_done && ahbl_hresp;

    // Errored reads still produce a (zero) response so upstream in-flight counts stay balanced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata_vld <= 1'b0;
            mem_rdata     <= 16'h0;
        end else begin
            mem_rdata_vld <= dph_done;
            if (dph_done)
                mem_rdata <= ahbl_hresp ? 16'h0 :
                             (dph_lane ? ahbl_hrdata[31:16] : ahbl_hrdata[15:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_sticky <= 1'b0;
        else if (dph_err)
            err_sticky <= 1'b1;
        else if (err_clr)
            err_sticky <= 1'b0;
    end

`ifdef RISCBOY_PPU_BRIDGE_ERR_CAPTURE_EN
    logic [W_HADDR-1:0] dph_haddr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dph_haddr <= '0;
        else if (ahbl_hready)
            dph_haddr <= ahbl_haddr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_addr <= '0;
        else if (dph_err && !err_sticky)
            err_addr <= dph_haddr;
    end
`endif

endmodule
